// File: rtl/gcd_pkg.sv
// Shared types and helpers for the GCD engine.
//   state_t : controller states (IDLE / CALC / DONE)
//   sat_inc : increment that sticks at the all-ones value of a given width
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Saturating increment for a w-bit counter (w <= 64). The caller sizes the
  // result back down to its own width.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] max;
    max = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max) ? max : v + 64'd1;
  endfunction

endpackage

// File: rtl/gcd_step.sv
// One subtractive-Euclid step, purely combinational.
//   a, b    : current operands (unsigned, WIDTH bits)
//   eq      : a == b (algorithm finished, result is a)
//   a_gt_b  : a > b
//   next_a  : a - b when a > b, else a
//   next_b  : b - a when b > a, else b
// Larger minus smaller only, so the subtract never wraps.
module gcd_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             a_gt_b,
  output logic [WIDTH-1:0] next_a,
  output logic [WIDTH-1:0] next_b
);

  assign eq     = (a == b);
  assign a_gt_b = (a > b);
  assign next_a = a_gt_b ? (a - b) : a;
  assign next_b = (!a_gt_b && !eq) ? (b - a) : b;

endmodule

// File: rtl/gcd_engine.sv
// Subtractive-Euclid GCD engine with valid/ready on both sides.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (ready only while idle)
//   in_a, in_b          : unsigned operands
//   out_valid/out_ready : result handshake (valid only while done)
//   out_gcd, out_iters  : registered result and saturating subtract count
//   busy                : high while iterating
// A zero operand short-circuits straight to the result (a|b, 0 iterations).
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic [CNT_W-1:0] out_iters,
  output logic             busy
);

  state_t            state, state_nx;
  logic [WIDTH-1:0]  a, b;
  logic [CNT_W-1:0]  cnt;
  logic              eq, a_gt_b;
  logic [WIDTH-1:0]  next_a, next_b;
  logic              zero_in;

  assign zero_in = (in_a == '0) || (in_b == '0);

  gcd_step #(.WIDTH(WIDTH)) u_step (
    .a      (a),
    .b      (b),
    .eq     (eq),
    .a_gt_b (a_gt_b),
    .next_a (next_a),
    .next_b (next_b)
  );

  // Next state and handshake/status decode straight from the state register.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = zero_in ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (eq) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      cnt       <= '0;
      out_gcd   <= '0;
      out_iters <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid) begin
          a   <= in_a;
          b   <= in_b;
          cnt <= '0;
          if (zero_in) begin
            out_gcd   <= in_a | in_b;
            out_iters <= '0;
          end
        end
        CALC: begin
          // Result registers only move on entry to DONE, so they stay
          // stable through DONE and after the handshake.
          if (eq) begin
            out_gcd   <= a;
            out_iters <= cnt;
          end else begin
            a   <= next_a;
            b   <= next_b;
            cnt <= CNT_W'(sat_inc(64'(cnt), CNT_W));
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// Bench for gcd_engine: two instances (CNT_W=16 and CNT_W=8) driven in
// lockstep; an expectation queue fed from a division-based Euclid model.
module tb_gcd_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [15:0] in_a, in_b;

  logic        in_ready16, out_valid16, busy16;
  logic [15:0] out_gcd16, out_iters16;
  logic        in_ready8, out_valid8, busy8;
  logic [15:0] out_gcd8;
  logic [7:0]  out_iters8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gcd_engine #(.WIDTH(16), .CNT_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid16), .out_ready(out_ready),
    .out_gcd(out_gcd16), .out_iters(out_iters16), .busy(busy16));

  gcd_engine #(.WIDTH(16), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid8), .out_ready(out_ready),
    .out_gcd(out_gcd8), .out_iters(out_iters8), .busy(busy8));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: Euclid by division. Subtract count = sum of quotients - 1,
  // since the last quotient's final subtraction is replaced by the A==B stop.
  function automatic void model(input longint a, input longint b,
                                output longint g, output longint k);
    longint x, y, t, s;
    if (a == 0 || b == 0) begin
      g = a | b;
      k = 0;
    end else begin
      x = a; y = b; s = 0;
      while (y != 0) begin
        s += x / y;
        t = x % y;
        x = y;
        y = t;
      end
      g = x;
      k = s - 1;
    end
  endfunction

  function automatic longint sat(input longint v, input longint max);
    return (v > max) ? max : v;
  endfunction

  typedef struct { longint g; longint k; } exp_t;
  exp_t q[$];

  // Compare process: every cycle the result is presented, check both DUTs
  // against the oldest outstanding expectation; enqueue on each accept.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid16 || out_valid8) begin
        chk("result_outstanding", q.size(), (q.size() == 0) ? 1 : q.size());
        if (q.size() != 0) begin
          chk("valid16", out_valid16, 1);
          chk("valid8", out_valid8, 1);
          chk("gcd16", out_gcd16, q[0].g);
          chk("iters16", out_iters16, sat(q[0].k, 65535));
          chk("gcd8", out_gcd8, q[0].g);
          chk("iters8", out_iters8, sat(q[0].k, 255));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready16) begin
        exp_t e;
        model(in_a, in_b, e.g, e.k);
        q.push_back(e);
      end
    end
  end

  // Wait (from #1 after an edge) until out_valid, counting busy cycles.
  task automatic wait_done(output int lat, output int bc);
    lat = 0; bc = 0;
    while (!out_valid16 && lat < 70000) begin
      if (busy16) bc++;
      @(posedge clk); #1;
      lat++;
    end
    chk("done_timeout", out_valid16, 1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready16 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_timeout", in_ready16, 1);
  endtask

  // Offer one pair and check latency, busy length, result and idle return.
  task automatic run_pair(input logic [15:0] a, input logic [15:0] b,
                          input int exp_lat, input longint eg,
                          input longint ei16, input longint ei8);
    int lat, bc;
    wait_ready();
    in_valid = 1'b1; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(lat, bc);
    chk("latency", lat, exp_lat);
    chk("busy_cycles", bc, exp_lat);
    chk("lit_gcd16", out_gcd16, eg);
    chk("lit_iters16", out_iters16, ei16);
    chk("lit_iters8", out_iters8, ei8);
    if (out_ready) begin
      @(posedge clk); #1;
      chk("idle_ready", in_ready16, 1);
      chk("idle_valid", out_valid16, 0);
      chk("gcd_kept", out_gcd16, eg);
    end
  endtask

  task automatic check_reset_state();
    chk("rst_in_ready16", in_ready16, 1);  chk("rst_in_ready8", in_ready8, 1);
    chk("rst_valid16", out_valid16, 0);    chk("rst_valid8", out_valid8, 0);
    chk("rst_busy16", busy16, 0);          chk("rst_busy8", busy8, 0);
    chk("rst_gcd16", out_gcd16, 0);        chk("rst_gcd8", out_gcd8, 0);
    chk("rst_iters16", out_iters16, 0);    chk("rst_iters8", out_iters8, 0);
  endtask

  initial begin
    longint g, k;
    int lat, bc;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;

    // Pin the model with hand-computed values.
    model(48, 18, g, k);    chk("model_48_18_g", g, 6);  chk("model_48_18_k", k, 4);
    model(1, 65535, g, k);  chk("model_1_max_g", g, 1);  chk("model_1_max_k", k, 65534);
    model(0, 0, g, k);      chk("model_0_0_g", g, 0);    chk("model_0_0_k", k, 0);

    // Directed vectors.
    run_pair(16'd48, 16'd18, 5, 6, 4, 4);
    run_pair(16'd7,  16'd7,  1, 7, 0, 0);
    run_pair(16'd0,  16'd5,  0, 5, 0, 0);
    run_pair(16'd0,  16'd0,  0, 0, 0, 0);
    run_pair(16'd1,  16'd65535, 65535, 1, 65534, 255);

    // Backpressure: result held, new offer ignored until the handshake.
    out_ready = 1'b0;
    run_pair(16'd12, 16'd8, 3, 4, 2, 2);
    in_valid = 1'b1; in_a = 16'd9; in_b = 16'd3;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid16, 1);
      chk("bp_in_ready", in_ready16, 0);
      chk("bp_gcd", out_gcd16, 4);
      chk("bp_iters", out_iters16, 2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;             // handshake edge
    chk("bp_release_ready", in_ready16, 1);
    @(posedge clk); #1;             // (9,3) accepted here
    in_valid = 1'b0;
    wait_done(lat, bc);
    chk("bp_next_lat", lat, 3);
    chk("bp_next_gcd", out_gcd16, 3);
    chk("bp_next_iters", out_iters16, 2);
    @(posedge clk); #1;

    // Reset in the middle of a calculation.
    wait_ready();
    in_valid = 1'b1; in_a = 16'd1000; in_b = 16'd3;
    @(posedge clk); #1;             // E0
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy16, 1);
    rst = 1'b1;
    @(posedge clk); #1;             // E0+4 samples reset
    check_reset_state();
    rst = 1'b0;
    run_pair(16'd21, 16'd14, 3, 7, 2, 2);

    // Random small pairs, expectations from the model.
    for (int i = 0; i < 20; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255));
      model(ra, rb, g, k);
      run_pair(ra, rb, (ra == 0 || rb == 0) ? 0 : int'(k) + 1,
               g, sat(k, 65535), sat(k, 255));
    end

    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
